// File: rtl/hamming_frame_rx_if.sv
// Frame bus between the Hamming-encoded word source and hamming_frame_rx.
// Widths follow the same codeword/dataword relationship as the receiver.
interface hamming_frame_rx_if #(
    parameter int DCW    = 15,
    parameter int MCW    = 9,
    parameter int NWORDS = 16
);
    localparam int DDW = DCW - $clog2(DCW + 1);
    localparam int MDW = MCW - $clog2(MCW + 1);

    logic                    in_valid;
    logic [DCW-1:0]          in_data;
    logic [MCW-1:0]          in_mode;
    logic                    out_valid;
    logic [MDW-1:0]          out_mode;
    logic [NWORDS*DDW-1:0]   out_data;
    logic [NWORDS:0]         out_corr;
    logic                    out_abort;

    modport master (
        output in_valid, in_data, in_mode,
        input  out_valid, out_mode, out_data, out_corr, out_abort
    );

    modport slave (
        input  in_valid, in_data, in_mode,
        output out_valid, out_mode, out_data, out_corr, out_abort
    );
endinterface

// File: rtl/hamming_frame_rx.sv
// Frame receiver: Hamming-SEC decodes NWORDS data words plus one mode word
// and presents the whole frame for one cycle; partial frames are aborted.

module hamming_sec_dec #(
    parameter int W  = 15,
    parameter int DW = W - $clog2(W + 1)
) (
    input  logic [W-1:0]  code,
    output logic [DW-1:0] data,
    output logic          corr
);
    localparam int SW = $clog2(W + 1);
    localparam int IW = $clog2(W);

    logic [SW-1:0] syn;
    logic [W-1:0]  fixed;

    // Position p lives at code[W-p]; a syndrome beyond W flags but cannot be repaired.
    always_comb begin
        syn = '0;
        for (int p = 1; p <= W; p++) begin
            if (code[IW'(W - p)]) syn = syn ^ SW'(p);
        end
        fixed = code;
        corr  = (syn != '0);
        if (syn != '0 && int'(syn) <= W) fixed[IW'(W - int'(syn))] = ~fixed[IW'(W - int'(syn))];
        data = '0;
        for (int p = 1; p <= W; p++) begin
            if ((p & (p - 1)) != 0) data = {data[DW-2:0], fixed[IW'(W - p)]};
        end
    end
endmodule

module hamming_frame_rx #(
    parameter int DCW    = 15,
    parameter int MCW    = 9,
    parameter int NWORDS = 16
) (
    input logic               clk,
    input logic               rst,
    hamming_frame_rx_if.slave bus
);
    localparam int DDW = DCW - $clog2(DCW + 1);
    localparam int MDW = MCW - $clog2(MCW + 1);
    localparam int CW  = $clog2(NWORDS + 1);
    localparam int IW  = $clog2(NWORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, OUT = 2'd2} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       count, count_next;
    logic [IW-1:0]       wr_idx;
    logic                store_word, first_word, abort_now;
    logic [DDW-1:0]      words [NWORDS];
    logic [NWORDS-1:0]   word_corr;
    logic [MDW-1:0]      mode_q;
    logic                mode_corr;
    logic                abort_q;
    logic [DDW-1:0]      data_dec;
    logic                data_corr;
    logic [MDW-1:0]      mode_dec;
    logic                mode_corr_dec;
    logic [NWORDS*DDW-1:0] data_flat;

    hamming_sec_dec #(.W(DCW)) u_data_dec (.code(bus.in_data), .data(data_dec), .corr(data_corr));
    hamming_sec_dec #(.W(MCW)) u_mode_dec (.code(bus.in_mode), .data(mode_dec), .corr(mode_corr_dec));

    // OUT doubles as a start state so a new frame may follow the output cycle directly.
    always_comb begin
        state_next = state;
        count_next = count;
        wr_idx     = '0;
        store_word = 1'b0;
        first_word = 1'b0;
        abort_now  = 1'b0;
        case (state)
            IDLE, OUT: begin
                if (bus.in_valid) begin
                    store_word = 1'b1;
                    first_word = 1'b1;
                    count_next = CW'(1);
                    state_next = COLLECT;
                end else begin
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    store_word = 1'b1;
                    wr_idx     = count[IW-1:0];
                    count_next = count + CW'(1);
                    if (count == CW'(NWORDS - 1)) state_next = OUT;
                end else begin
                    abort_now  = 1'b1;
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                count_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            abort_q   <= 1'b0;
            words     <= '{default: '0};
            word_corr <= '0;
            mode_q    <= '0;
            mode_corr <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            abort_q <= abort_now;
            if (store_word) begin
                words[wr_idx]     <= data_dec;
                word_corr[wr_idx] <= data_corr;
            end
            if (first_word) begin
                mode_q    <= mode_dec;
                mode_corr <= mode_corr_dec;
            end
        end
    end

    // Word 0 occupies the most significant slice of the flattened frame.
    for (genvar k = 0; k < NWORDS; k++) begin : g_flat
        assign data_flat[(NWORDS-1-k)*DDW +: DDW] = words[k];
    end

    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = (state == OUT) ? data_flat : '0;
    assign bus.out_mode  = (state == OUT) ? mode_q : '0;
    assign bus.out_corr  = (state == OUT) ? {mode_corr, word_corr} : '0;
    assign bus.out_abort = abort_q;
endmodule

// File: tb/tb_hamming_frame_rx.sv
// Directed bench for hamming_frame_rx: table of encoded frames with injected
// bit flips, plus abort, back-to-back and mid-frame reset sequences.
module tb_hamming_frame_rx;
    localparam int DCW    = 15;
    localparam int MCW    = 9;
    localparam int NWORDS = 16;
    localparam int DDW    = 11;
    localparam int MDW    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hamming_frame_rx_if #(.DCW(DCW), .MCW(MCW), .NWORDS(NWORDS)) bus ();
    hamming_frame_rx #(.DCW(DCW), .MCW(MCW), .NWORDS(NWORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int              base;
        logic [MDW-1:0]  mode;
        int              flip_word;
        int              flip_pos;
        int              mflip_a;
        int              mflip_b;
        logic [NWORDS:0] corr;
    } vec_t;

    typedef struct {
        int                    first_cyc;
        logic [MDW-1:0]        mode;
        logic [NWORDS:0]       corr;
        logic [NWORDS*DDW-1:0] data;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   valid_pulses = 0;
    int   abort_pulses = 0;
    int   saved_valid, saved_abort;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Encoder: data bits fill non-power-of-two positions MSB first, even parity at powers of two.
    function automatic logic [15:0] encode(input logic [15:0] d, input int w, input int dw);
        logic [15:0] pos;
        logic [15:0] cw;
        logic        par;
        int          j;
        pos = '0;
        j   = dw - 1;
        for (int p = 1; p <= w; p++) begin
            if ((p & (p - 1)) != 0) begin
                pos[4'(p)] = d[4'(j)];
                j--;
            end
        end
        for (int b = 1; b <= w; b = b * 2) begin
            par = 1'b0;
            for (int p = 1; p <= w; p++)
                if (((p & b) != 0) && (p != b)) par = par ^ pos[4'(p)];
            pos[4'(b)] = par;
        end
        cw = '0;
        for (int p = 1; p <= w; p++) cw[4'(w - p)] = pos[4'(p)];
        return cw;
    endfunction

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: frame contents and latency on out_valid, zeros otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check_output("no_overlap", 256'(bus.out_valid & bus.out_abort), 256'(0));
            if (bus.out_abort === 1'b1) abort_pulses++;
            if (bus.out_valid === 1'b1) begin
                valid_pulses++;
                check_output("scoreboard_nonempty", 256'(sb.size() != 0), 256'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_output("latency_cycle", 256'(cyc - e.first_cyc + 1), 256'(NWORDS + 1));
                    check_output("out_mode", 256'(bus.out_mode), 256'(e.mode));
                    check_output("out_corr", 256'(bus.out_corr), 256'(e.corr));
                    check_output("out_data", 256'(bus.out_data), 256'(e.data));
                end
            end else begin
                check_output("zero_when_idle", 256'({bus.out_data, bus.out_mode, bus.out_corr}), 256'(0));
                if (sb.size() != 0 && (cyc - sb[0].first_cyc + 1) > NWORDS + 1) begin
                    check_output("missing_valid", 256'(bus.out_valid), 256'(1));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 'x;
            bus.in_mode  = 'x;
        end
    endtask

    // Drives the first nsend words of table row 'row'; complete frames go to the scoreboard.
    task automatic apply_stimulus(input int row, input int nsend);
        vec_t        v;
        exp_t        e;
        logic [15:0] cw;
        logic [15:0] mcw;
        v   = vecs[row];
        mcw = encode(16'(v.mode), MCW, MDW);
        if (v.mflip_a > 0) mcw[4'(MCW - v.mflip_a)] = ~mcw[4'(MCW - v.mflip_a)];
        if (v.mflip_b > 0) mcw[4'(MCW - v.mflip_b)] = ~mcw[4'(MCW - v.mflip_b)];
        e.mode      = v.mode;
        e.corr      = v.corr;
        e.first_cyc = 0;
        e.data      = '0;
        for (int k = 0; k < NWORDS; k++) e.data[(NWORDS-1-k)*DDW +: DDW] = 11'(v.base + k);
        for (int k = 0; k < nsend; k++) begin
            cw = encode({5'b0, 11'(v.base + k)}, DCW, DDW);
            if (k == v.flip_word) cw[4'(DCW - v.flip_pos)] = ~cw[4'(DCW - v.flip_pos)];
            @(negedge clk);
            if (k == 0) e.first_cyc = cyc;
            bus.in_valid = 1'b1;
            bus.in_data  = cw[DCW-1:0];
            bus.in_mode  = (k == 0) ? mcw[MCW-1:0] : 'x;
        end
        if (nsend == NWORDS) sb.push_back(e);
    endtask

    initial begin
        logic [15:0] cw9;
        vecs[0] = '{base: -8,    mode: 5'b00100, flip_word: -1, flip_pos: 0,  mflip_a: 0, mflip_b: 0, corr: 17'h00000};
        vecs[1] = '{base: -8,    mode: 5'b00100, flip_word: 3,  flip_pos: 5,  mflip_a: 1, mflip_b: 0, corr: 17'h10008};
        vecs[2] = '{base: -8,    mode: 5'b00100, flip_word: 15, flip_pos: 8,  mflip_a: 0, mflip_b: 0, corr: 17'h08000};
        vecs[3] = '{base: 100,   mode: 5'b10011, flip_word: 0,  flip_pos: 15, mflip_a: 0, mflip_b: 0, corr: 17'h00001};
        vecs[4] = '{base: -1024, mode: 5'b11111, flip_word: 7,  flip_pos: 3,  mflip_a: 4, mflip_b: 8, corr: 17'h10080};
        vecs[5] = '{base: 1008,  mode: 5'b00000, flip_word: -1, flip_pos: 0,  mflip_a: 0, mflip_b: 0, corr: 17'h00000};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        bus.in_mode  = 'x;
        repeat (2) @(negedge clk);
        check_output("reset_valid", 256'(bus.out_valid), 256'(0));
        check_output("reset_abort", 256'(bus.out_abort), 256'(0));
        check_output("reset_outputs", 256'({bus.out_data, bus.out_mode, bus.out_corr}), 256'(0));
        rst    = 1'b0;
        mon_en = 1'b1;

        $display("[TB] table-driven frames");
        for (int r = 0; r < 5; r++) begin
            apply_stimulus(r, NWORDS);
            idle(3);
        end

        $display("[TB] early abort after 7 words");
        apply_stimulus(0, 7);
        idle(1);
        @(negedge clk);
        check_output("abort_pulse", 256'(bus.out_abort), 256'(1));
        check_output("abort_no_valid", 256'(bus.out_valid), 256'(0));
        @(negedge clk);
        check_output("abort_one_cycle", 256'(bus.out_abort), 256'(0));
        apply_stimulus(0, NWORDS);
        idle(3);

        $display("[TB] back-to-back frames");
        apply_stimulus(5, NWORDS);
        apply_stimulus(1, NWORDS);
        idle(3);

        $display("[TB] reset at word 9");
        saved_valid = valid_pulses;
        saved_abort = abort_pulses;
        apply_stimulus(3, 9);
        cw9 = encode({5'b0, 11'(109)}, DCW, DDW);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = cw9[DCW-1:0];
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        check_output("rst_mid_outputs", 256'({bus.out_valid, bus.out_abort, bus.out_data, bus.out_mode, bus.out_corr}), 256'(0));
        idle(20);
        check_output("rst_mid_no_valid", 256'(valid_pulses), 256'(saved_valid));
        check_output("rst_mid_no_abort", 256'(abort_pulses), 256'(saved_abort));
        apply_stimulus(4, NWORDS);
        idle(4);

        check_output("total_valid_pulses", 256'(valid_pulses), 256'(9));
        check_output("total_abort_pulses", 256'(abort_pulses), 256'(1));
        check_output("scoreboard_drained", 256'(sb.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
